// File: rtl/reg_file.sv
// reg_file: architectural register file for the 8-bit emulator datapath.
//
// 2**addr_width registers (R0..CR). R0 always reads zero and ignores writes.
// CR (the highest address) is also the target of the dedicated carry port.
// Two combinational read ports feed the ALU operands; the result write port
// and the carry port update the array on the rising clock edge. Registered
// zero/jump flags are kept for the branch logic.
//
// Optional feature: define REG_FILE_BYPASS_EN to forward this cycle's write
// data combinationally onto the read ports (result data wins over carry data).
//
// Ports:
//   clk          clock, all state updates on rising edge
//   reset        asynchronous active-high reset, clears all state
//   ra_addr      read port A address      ra_out  read port A data
//   rb_addr      read port B address      rb_out  read port B data
//   wr_en        result write enable
//   wr_addr      result write address
//   wr_data      result write data
//   car_en       carry write enable
//   car_data     carry write data (targets CR)
//   flag_en      flag capture enable
//   zero_in      zero flag input          zero_flag  registered zero flag
//   jump_in      jump flag input          jump_flag  registered jump flag
//   wr_conflict  one-cycle pulse after result and carry both targeted CR
module reg_file #(
    parameter int unsigned reg_width  = 8,
    parameter int unsigned addr_width = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] ra_addr,
    input  logic [addr_width-1:0] rb_addr,
    output logic [reg_width-1:0]  ra_out,
    output logic [reg_width-1:0]  rb_out,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [reg_width-1:0]  wr_data,
    input  logic                  car_en,
    input  logic [reg_width-1:0]  car_data,
    input  logic                  flag_en,
    input  logic                  zero_in,
    input  logic                  jump_in,
    output logic                  zero_flag,
    output logic                  jump_flag,
    output logic                  wr_conflict
);

    localparam int unsigned num_regs = 1 << addr_width;
    localparam logic [addr_width-1:0] cr_addr = '1;

    logic [reg_width-1:0] regs [num_regs];

    logic collide;
    assign collide = wr_en && (wr_addr == cr_addr) && car_en;

    // Carry is applied first so a result write to CR in the same cycle
    // overrides it; that is the collision priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < num_regs; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (car_en) begin
                regs[cr_addr] <= car_data;
            end
            if (wr_en && (wr_addr != '0)) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_flag   <= 1'b0;
            jump_flag   <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= collide;
            if (flag_en) begin
                zero_flag <= zero_in;
                jump_flag <= jump_in;
            end
        end
    end

    always_comb begin
        ra_out = regs[ra_addr];
`ifdef REG_FILE_BYPASS_EN
        if (car_en && (ra_addr == cr_addr)) begin
            ra_out = car_data;
        end
        if (wr_en && (ra_addr == wr_addr)) begin
            ra_out = wr_data;
        end
`endif
        if (ra_addr == '0) begin
            ra_out = '0;
        end
    end

    always_comb begin
        rb_out = regs[rb_addr];
`ifdef REG_FILE_BYPASS_EN
        if (car_en && (rb_addr == cr_addr)) begin
            rb_out = car_data;
        end
        if (wr_en && (rb_addr == wr_addr)) begin
            rb_out = wr_data;
        end
`endif
        if (rb_addr == '0) begin
            rb_out = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed cases followed by randomized traffic,
// checked against a behavioural model through an expectation queue.
module tb_reg_file;

    logic       clk;
    logic       reset;
    logic [3:0] ra_addr;
    logic [3:0] rb_addr;
    logic [7:0] ra_out;
    logic [7:0] rb_out;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       car_en;
    logic [7:0] car_data;
    logic       flag_en;
    logic       zero_in;
    logic       jump_in;
    logic       zero_flag;
    logic       jump_flag;
    logic       wr_conflict;

    reg_file #(
        .reg_width (8),
        .addr_width(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .ra_out     (ra_out),
        .rb_out     (rb_out),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .car_en     (car_en),
        .car_data   (car_data),
        .flag_en    (flag_en),
        .zero_in    (zero_in),
        .jump_in    (jump_in),
        .zero_flag  (zero_flag),
        .jump_flag  (jump_flag),
        .wr_conflict(wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ra;
        logic [7:0] rb;
        logic       zf;
        logic       jf;
        logic       wc;
    } exp_t;

    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [7:0] mdl [16];
    logic       m_zf;
    logic       m_jf;
    logic       m_wc;

    function automatic logic [7:0] model_read(input logic [3:0] a);
        if (a == 4'd0) return 8'h00;
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
        if (car_en && a == 4'd15) return car_data;
`endif
        return mdl[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        m_zf = 1'b0;
        m_jf = 1'b0;
        m_wc = 1'b0;
    endtask

    task automatic push_expect();
        exp_t e;
        e.ra = model_read(ra_addr);
        e.rb = model_read(rb_addr);
        e.zf = m_zf;
        e.jf = m_jf;
        e.wc = m_wc;
        exp_q.push_back(e);
    endtask

    // One cycle of traffic: drive after the falling edge, record what the
    // outputs must show before the next rising edge, then advance the model.
    task automatic step(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic ce, input logic [7:0] cd,
                        input logic fe, input logic zi, input logic ji,
                        input logic [3:0] ra, input logic [3:0] rb);
        @(negedge clk);
        reset = 1'b0;
        wr_en = we; wr_addr = wa; wr_data = wd;
        car_en = ce; car_data = cd;
        flag_en = fe; zero_in = zi; jump_in = ji;
        ra_addr = ra; rb_addr = rb;
        #1;
        push_expect();
        // next state of the model
        m_wc = we && (wa == 4'd15) && ce;
        if (ce && !(we && wa == 4'd15)) mdl[15] = cd;
        if (we && wa != 4'd0) mdl[wa] = wd;
        if (fe) begin
            m_zf = zi;
            m_jf = ji;
        end
    endtask

    // Assert reset between edges with no writes presented; held over one edge.
    task automatic reset_step(input logic [3:0] ra, input logic [3:0] rb);
        @(negedge clk);
        wr_en = 1'b0; car_en = 1'b0; flag_en = 1'b0;
        ra_addr = ra; rb_addr = rb;
        reset = 1'b1;
        #1;
        model_clear();
        push_expect();
    endtask

    // Monitor: outputs are sampled mid-cycle, well clear of the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compared++;
                if (ra_out !== e.ra) begin
                    mismatched++;
                    $display("FAIL ra_out t=%0t addr=%0d got=%h exp=%h", $time, ra_addr, ra_out, e.ra);
                end
                compared++;
                if (rb_out !== e.rb) begin
                    mismatched++;
                    $display("FAIL rb_out t=%0t addr=%0d got=%h exp=%h", $time, rb_addr, rb_out, e.rb);
                end
                compared++;
                if (zero_flag !== e.zf) begin
                    mismatched++;
                    $display("FAIL zero_flag t=%0t got=%b exp=%b", $time, zero_flag, e.zf);
                end
                compared++;
                if (jump_flag !== e.jf) begin
                    mismatched++;
                    $display("FAIL jump_flag t=%0t got=%b exp=%b", $time, jump_flag, e.jf);
                end
                compared++;
                if (wr_conflict !== e.wc) begin
                    mismatched++;
                    $display("FAIL wr_conflict t=%0t got=%b exp=%b", $time, wr_conflict, e.wc);
                end
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        car_en = 1'b0; car_data = '0;
        flag_en = 1'b0; zero_in = 1'b0; jump_in = 1'b0;
        ra_addr = '0; rb_addr = '0;
        model_clear();

        // Reset state
        reset_step(4'd3, 4'd15);

        // Write R3=0x5A, read it, then reset between edges
        step(1, 4'd3, 8'h5A, 0, 8'h00, 1, 1, 1, 4'd3, 4'd3);
        step(0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 4'd3, 4'd3);
        reset_step(4'd3, 4'd3);
        step(0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 4'd3, 4'd3);

        // Basic write/read
        step(1, 4'd3, 8'hF0, 0, 8'h00, 0, 0, 0, 4'd3, 4'd3);
        step(0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 4'd3, 4'd3);

        // R0 protection
        step(1, 4'd0, 8'hFF, 0, 8'h00, 0, 0, 0, 4'd0, 4'd0);
        step(0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 4'd0, 4'd3);

        // Carry, then collision, then conflict clears
        step(0, 4'd0, 8'h00, 1, 8'h01, 0, 0, 0, 4'd15, 4'd15);
        step(1, 4'd15, 8'h78, 1, 8'h02, 0, 0, 0, 4'd15, 4'd15);
        step(0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 4'd15, 4'd15);
        step(0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 4'd15, 4'd15);

        // Result and carry to different registers in the same cycle
        step(1, 4'd7, 8'hA5, 1, 8'h33, 0, 0, 0, 4'd7, 4'd15);
        step(0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 4'd7, 4'd15);

        // Same-cycle read of R5 while rewriting it
        step(1, 4'd5, 8'h11, 0, 8'h00, 0, 0, 0, 4'd5, 4'd5);
        step(1, 4'd5, 8'h3C, 0, 8'h00, 0, 0, 0, 4'd5, 4'd5);
        step(0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 4'd5, 4'd5);

        // Flags capture then hold
        step(0, 4'd0, 8'h00, 0, 8'h00, 1, 1, 0, 4'd0, 4'd0);
        step(0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 1, 4'd0, 4'd0);
        step(0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 1, 4'd0, 4'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] wa;
            wa = ($urandom_range(3, 0) == 0) ? 4'd15 : 4'($urandom_range(15, 0));
            if ($urandom_range(49, 0) == 0) begin
                reset_step(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
            end else begin
                step(1'($urandom_range(1, 0)), wa, 8'($urandom_range(255, 0)),
                     1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)),
                     1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                     4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
            end
        end

        // Let the monitor drain, bounded
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #3;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the 8-bit emulator datapath, directly upstream of the ALU. Two combinational read ports drive the ALU `ra_in`/`rb_in` operands. A write port accepts the ALU `res_out` result, and a dedicated carry port stores `car_out` into a fixed carry register. The block also keeps registered `zero`/`jump` flags for the branch logic.

## Interface
- `reg_width`, 8, data width of every register and port.
- `addr_width`, 4, register address width; 2**addr_width registers.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ra_addr`  in  addr_width  read port A address.
- `rb_addr`  in  addr_width  read port B address.
- `ra_out`  out  reg_width  read port A data, to ALU `ra_in`.
- `rb_out`  out  reg_width  read port B data, to ALU `rb_in`.
- `wr_en`  in  1  result write enable.
- `wr_addr`  in  addr_width  result write address.
- `wr_data`  in  reg_width  result data, from ALU `res_out`.
- `car_en`  in  1  carry write enable.
- `car_data`  in  reg_width  carry data, from ALU `car_out`; targets register CR = 2**addr_width-1.
- `flag_en`  in  1  flag capture enable.
- `zero_in`  in  1  from ALU `zero`.
- `jump_in`  in  1  from ALU `jump`.
- `zero_flag`  out  1  registered zero flag.
- `jump_flag`  out  1  registered jump flag.
- `wr_conflict`  out  1  one-cycle pulse: result and carry wrote CR in the same cycle.

## Operation
- Storage: 2**addr_width registers of reg_width bits, R0..CR.
- R0 is hardwired:
  - reads always return 0;
  - writes to R0, on either port, are discarded.
- Reads are combinational from the array: `ra_out = R[ra_addr]` and `rb_out = R[rb_addr]`. Both ports may read the same address.
- Result write: on a rising edge with `wr_en=1` and `wr_addr!=0`, `R[wr_addr] <= wr_data`.
- Carry write: on a rising edge with `car_en=1`, `R[CR] <= car_data`.
- Collision: when `wr_en=1`, `wr_addr=CR` and `car_en=1`:
  - the result write wins and the carry data is dropped;
  - `wr_conflict` is 1 for the following cycle only.
- Flags: on a rising edge with `flag_en=1`, `zero_flag <= zero_in` and `jump_flag <= jump_in`. Otherwise both hold.
- Writes to different addresses in the same cycle, result to Rn plus carry to CR with n != CR, both take effect.

## Timing
- Reset values: all registers = 0, `zero_flag=0`, `jump_flag=0`, `wr_conflict=0`. With all registers 0, `ra_out`/`rb_out` read 0.
- Reset asserted mid-operation clears state immediately, independent of `clk`. Writes presented on the edge coincident with reset are lost.
- First write is accepted on the first rising edge after `reset` deasserts.
- Read latency: 0 cycles from address change.
- Write-to-read latency: 1 cycle. The value written at edge k is visible on the read ports after edge k.
- Same-cycle read of an address being written returns the old value, unless bypass is enabled (see Configuration).
- Flag latency: 1 cycle.
- `wr_conflict` latency: 1 cycle, width exactly one cycle per colliding edge.

## Configuration
- `REG_FILE_BYPASS_EN` defined: write-through forwarding on both read ports. The data that will be written at the next edge is returned combinationally:
  - if `ra_addr`/`rb_addr` equals a write target of this cycle (`wr_addr` with `wr_en`, or CR with `car_en`), the port returns the incoming data;
  - result data takes priority over carry data, matching the collision rule;
  - R0 still reads 0.
- Not defined: no forwarding. Reads always return the stored array contents; same-cycle reads of a written address return the pre-edge value.

## Test plan
- Reset: write R3=0x5A, then assert `reset` between edges -> all reads return 0x00 immediately; `zero_flag=jump_flag=wr_conflict=0`.
- Basic write/read: `wr_en=1`, `wr_addr=3`, `wr_data=0xF0`, then `ra_addr=3`, `rb_addr=3` -> both ports return 0xF0 after the edge.
- R0 protection: write 0xFF to R0 -> `ra_addr=0` returns 0x00.
- Carry and collision:
  - `car_en=1`, `car_data=0x01` -> R15 = 0x01;
  - next edge, `wr_en=1`, `wr_addr=15`, `wr_data=0x78`, `car_en=1`, `car_data=0x02` -> R15 = 0x78, `wr_conflict` high for exactly one cycle.
- Same-cycle read while writing R5=0x3C, with R5 previously 0x11 ->
  - without `REG_FILE_BYPASS_EN`: `ra_out=0x11` before the edge, 0x3C after;
  - with it: `ra_out=0x3C` before the edge.
- Flags:
  - `flag_en=1`, `zero_in=1`, `jump_in=0` -> `zero_flag=1`, `jump_flag=0` after the edge;
  - `flag_en=0`, `zero_in=0` -> flags hold.
